// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge sequencer.
package interrupt_ack_sequencer_pkg;

  localparam int unsigned CASC_W_DEFAULT = 3;
  localparam logic [7:0]  CALL_OPCODE    = 8'hCD;
  // Id reported when INTA arrives with no request pending (IR7 convention).
  localparam int unsigned SPURIOUS_ID    = 7;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StP1,
    StGap1,
    StP2,
    StGap2,
    StP3,
    StDone
  } ack_state_t;

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Bundle of resolver, configuration, CPU and cascade signals around the sequencer.
interface interrupt_ack_sequencer_if
  import interrupt_ack_sequencer_pkg::*;
#(
  parameter int unsigned CASC_W = CASC_W_DEFAULT,
  parameter int unsigned NUM_IR = 2 ** CASC_W
) ();

  logic              inta_neg;
  logic              single_mode_flag;
  logic              sp_neg;
  logic              mode_8086_flag;
  logic              aeoi_flag;
  logic              int_request;
  logic [CASC_W-1:0] highest_id;
  logic [NUM_IR-1:0] slaves_connected_flag;
  logic [CASC_W-1:0] my_slave_id;
  logic [CASC_W-1:0] cascade_in;
  logic [4:0]        vector_base;
  logic [7:0]        addr_low;
  logic [7:0]        addr_high;

  logic              int_out;
  logic [CASC_W-1:0] cascade_out;
  logic              cascade_oe;
  logic [7:0]        data_out;
  logic              data_oe;
  logic              isr_set_strobe;
  logic              isr_clear_strobe;
  logic [CASC_W-1:0] ack_id;
  logic              freeze_irr;

  // Environment side: CPU pins, resolver and configuration registers.
  modport master (
    output inta_neg, single_mode_flag, sp_neg, mode_8086_flag, aeoi_flag, int_request,
           highest_id, slaves_connected_flag, my_slave_id, cascade_in, vector_base,
           addr_low, addr_high,
    input  int_out, cascade_out, cascade_oe, data_out, data_oe, isr_set_strobe,
           isr_clear_strobe, ack_id, freeze_irr
  );

  // Sequencer side.
  modport slave (
    input  inta_neg, single_mode_flag, sp_neg, mode_8086_flag, aeoi_flag, int_request,
           highest_id, slaves_connected_flag, my_slave_id, cascade_in, vector_base,
           addr_low, addr_high,
    output int_out, cascade_out, cascade_oe, data_out, data_oe, isr_set_strobe,
           isr_clear_strobe, ack_id, freeze_irr
  );

endinterface

// File: rtl/interrupt_ack_sequencer_inta_edge_sync.sv
// Two-flop synchroniser for the asynchronous INTA pin plus fall/rise pulse detection.
module interrupt_ack_sequencer_inta_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic inta_neg_i,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;

  // Idle level of INTA is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= inta_neg_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_o = prev_q & ~sync2_q;
  assign rise_o = ~prev_q & sync2_q;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt-acknowledge sequencer: INT/INTA handshake, id latch, cascade and vector drive.
module interrupt_ack_sequencer
  import interrupt_ack_sequencer_pkg::*;
#(
  parameter int unsigned CASC_W = CASC_W_DEFAULT,
  parameter int unsigned NUM_IR = 2 ** CASC_W
) (
  input logic                  clk,
  input logic                  reset,
  interrupt_ack_sequencer_if.slave bus
);

  logic fall, rise;

  interrupt_ack_sequencer_inta_edge_sync u_inta_sync (
    .clk       (clk),
    .reset     (reset),
    .inta_neg_i(bus.inta_neg),
    .fall_o    (fall),
    .rise_o    (rise)
  );

  ack_state_t        state_q, state_d;
  logic [CASC_W-1:0] ack_id_q, ack_id_d;
  logic              spurious_q, spurious_d;
  logic              mode_8086_q, mode_8086_d;
  logic              match_q, match_d;

  logic              int_out_q, int_out_d;
  logic [CASC_W-1:0] cascade_out_q, cascade_out_d;
  logic              cascade_oe_q, cascade_oe_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              set_q, set_d;
  logic              clr_q, clr_d;
  logic              freeze_q, freeze_d;

  logic [NUM_IR-1:0] conn;
  logic              in_ack, live_match, drives;

  assign conn = bus.slaves_connected_flag;

  // Next-state and latched-cycle context.
  always_comb begin
    state_d     = state_q;
    ack_id_d    = ack_id_q;
    spurious_d  = spurious_q;
    mode_8086_d = mode_8086_q;
    match_d     = match_q;
    set_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          // INTA without a raised INT: run a full spurious cycle.
          state_d     = StP1;
          ack_id_d    = CASC_W'(SPURIOUS_ID);
          spurious_d  = 1'b1;
          mode_8086_d = bus.mode_8086_flag;
          match_d     = 1'b0;
        end else if (bus.int_request) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (fall) begin
          state_d     = StP1;
          mode_8086_d = bus.mode_8086_flag;
          match_d     = 1'b0;
          if (bus.int_request) begin
            ack_id_d   = bus.highest_id;
            spurious_d = 1'b0;
            set_d      = 1'b1;
          end else begin
            ack_id_d   = CASC_W'(SPURIOUS_ID);
            spurious_d = 1'b1;
          end
        end
      end
      StP1: begin
        if (rise) begin
          state_d = StGap1;
          match_d = (bus.cascade_in == bus.my_slave_id);
        end
      end
      StGap1: if (fall) state_d = StP2;
      StP2:   if (rise) state_d = mode_8086_q ? StDone : StGap2;
      StGap2: if (fall) state_d = StP3;
      StP3:   if (rise) state_d = StDone;
      StDone: state_d = StIdle;
    endcase
  end

  // Output decode from the upcoming state so outputs register alongside it.
  always_comb begin
    in_ack     = (state_d == StP1) || (state_d == StGap1) || (state_d == StP2) ||
                 (state_d == StGap2) || (state_d == StP3);
    live_match = (bus.cascade_in == bus.my_slave_id);
    if (bus.single_mode_flag) begin
      drives = 1'b1;
    end else if (bus.sp_neg) begin
      drives = ~conn[ack_id_d];
    end else begin
      // The slave match is only latched at the first rise; use the pins during P1.
      drives = (state_d == StP1) ? live_match : match_d;
    end

    int_out_d     = (state_d == StReq);
    freeze_d      = in_ack;
    cascade_oe_d  = in_ack & bus.sp_neg & ~bus.single_mode_flag & conn[ack_id_d];
    cascade_out_d = cascade_oe_d ? ack_id_d : '0;
    clr_d         = (state_d == StDone) & bus.aeoi_flag & ~spurious_q;

    data_oe_d  = 1'b0;
    data_out_d = 8'h00;
    if (state_d == StP1) begin
      if (!mode_8086_d && drives) begin
        data_oe_d  = 1'b1;
        data_out_d = CALL_OPCODE;
      end
    end else if (state_d == StP2) begin
      data_oe_d  = drives;
      data_out_d = mode_8086_d ? 8'({bus.vector_base, ack_id_d}) : bus.addr_low;
    end else if (state_d == StP3) begin
      data_oe_d  = drives;
      data_out_d = bus.addr_high;
    end
  end

  // State, cycle context and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ack_id_q      <= '0;
      spurious_q    <= 1'b0;
      mode_8086_q   <= 1'b0;
      match_q       <= 1'b0;
      int_out_q     <= 1'b0;
      cascade_out_q <= '0;
      cascade_oe_q  <= 1'b0;
      data_out_q    <= 8'h00;
      data_oe_q     <= 1'b0;
      set_q         <= 1'b0;
      clr_q         <= 1'b0;
      freeze_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_id_q      <= ack_id_d;
      spurious_q    <= spurious_d;
      mode_8086_q   <= mode_8086_d;
      match_q       <= match_d;
      int_out_q     <= int_out_d;
      cascade_out_q <= cascade_out_d;
      cascade_oe_q  <= cascade_oe_d;
      data_out_q    <= data_out_d;
      data_oe_q     <= data_oe_d;
      set_q         <= set_d;
      clr_q         <= clr_d;
      freeze_q      <= freeze_d;
    end
  end

  assign bus.int_out          = int_out_q;
  assign bus.cascade_out      = cascade_out_q;
  assign bus.cascade_oe       = cascade_oe_q;
  assign bus.data_out         = data_out_q;
  assign bus.data_oe          = data_oe_q;
  assign bus.isr_set_strobe   = set_q;
  assign bus.isr_clear_strobe = clr_q;
  assign bus.ack_id           = ack_id_q;
  assign bus.freeze_irr       = freeze_q;

endmodule
